// File: rtl/mpi_ahb3_pkg.sv
// rtl/mpi_ahb3_pkg.sv - AHB3-Lite encodings and FSM state codes for the MPI buffer slave
package mpi_ahb3_pkg;
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_WORD = 3'b010;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_ERR1   = 2'd2;
   localparam logic [1:0] ST_ERR2   = 2'd3;

   function automatic logic htrans_active(input logic [1:0] htrans);
      return !(htrans == HTRANS_IDLE || htrans == HTRANS_BUSY) &&
             (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
   endfunction
endpackage

// File: rtl/mpi_ahb3_timeout.sv
// rtl/mpi_ahb3_timeout.sv - wait-state counter that flags when a bus access has stalled too long
module mpi_ahb3_timeout #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expire
);
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en)
         cnt <= cnt + CW'(1);
   end

   assign expire = en & (cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/mpi_ahb3_slave_if.sv
// rtl/mpi_ahb3_slave_if.sv - AHB3-Lite slave bridging to the MPI message buffer bus port
module mpi_ahb3_slave_if
   import mpi_ahb3_pkg::*;
#(
   parameter int PLEN    = 32,
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ahb3_hsel_i,
   input  logic [PLEN-1:0] ahb3_haddr_i,
   input  logic [XLEN-1:0] ahb3_hwdata_i,
   input  logic            ahb3_hwrite_i,
   input  logic [2:0]      ahb3_hsize_i,
   input  logic [2:0]      ahb3_hburst_i,
   input  logic [3:0]      ahb3_hprot_i,
   input  logic [1:0]      ahb3_htrans_i,
   input  logic            ahb3_hmastlock_i,
   input  logic            ahb3_hready_i,
   output logic            ahb3_hreadyout_o,
   output logic            ahb3_hresp_o,
   output logic [XLEN-1:0] ahb3_hrdata_o,
   output logic [31:0]     bus_addr,
   output logic            bus_we,
   output logic            bus_en,
   output logic [31:0]     bus_data_in,
   input  logic [31:0]     bus_data_out,
   input  logic            bus_ack,
   input  logic            bus_err,
   output logic            timeout_o
);
   logic [1:0]      state, state_nxt;
   logic [PLEN-1:0] addr_q;
   logic            we_q;
   logic            capture, bad, in_access, wait_cyc, expire;
   logic            unused_ok;

   assign unused_ok = ^{ahb3_hburst_i, ahb3_hprot_i, ahb3_hmastlock_i};

   assign capture   = ahb3_hsel_i & ahb3_hready_i & htrans_active(ahb3_htrans_i);
   assign bad       = (ahb3_hsize_i != HSIZE_WORD) | (ahb3_haddr_i[1:0] != 2'b00);
   assign in_access = (state == ST_ACCESS);
   assign wait_cyc  = in_access & ~bus_ack & ~bus_err;

   // Counter only runs through uninterrupted wait cycles, so any other cycle restarts it.
   mpi_ahb3_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk    (clk),
      .rst    (rst),
      .clr    (~wait_cyc),
      .en     (wait_cyc),
      .expire (expire)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE, ST_ERR2:
            state_nxt = capture ? (bad ? ST_ERR1 : ST_ACCESS) : ST_IDLE;
         ST_ACCESS: begin
            if (bus_err || expire)
               state_nxt = ST_ERR1;
            else if (bus_ack)
               state_nxt = capture ? (bad ? ST_ERR1 : ST_ACCESS) : ST_IDLE;
         end
         ST_ERR1:
            state_nxt = ST_ERR2;
         default:
            state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         addr_q    <= '0;
         we_q      <= 1'b0;
         timeout_o <= 1'b0;
      end else begin
         state     <= state_nxt;
         timeout_o <= expire;
         if (capture) begin
            addr_q <= ahb3_haddr_i;
            we_q   <= ahb3_hwrite_i;
         end
      end
   end

   always_comb begin
      ahb3_hreadyout_o = 1'b1;
      ahb3_hresp_o     = HRESP_OKAY;
      case (state)
         ST_ACCESS: ahb3_hreadyout_o = bus_ack & ~bus_err;
         ST_ERR1: begin
            ahb3_hreadyout_o = 1'b0;
            ahb3_hresp_o     = HRESP_ERROR;
         end
         ST_ERR2:   ahb3_hresp_o = HRESP_ERROR;
         default:   ahb3_hreadyout_o = 1'b1;
      endcase
   end

   assign ahb3_hrdata_o = (in_access & bus_ack) ? XLEN'(bus_data_out) : '0;
   assign bus_en        = in_access;
   assign bus_addr      = 32'(addr_q);
   assign bus_we        = we_q;
   assign bus_data_in   = 32'(ahb3_hwdata_i);
endmodule
